// File: rtl/mips16_pkg.sv
// Shared definitions for the mips16 fetch front end: default widths and the
// program-counter sequencer state encoding.
package mips16_pkg;

   localparam int unsigned PC_W_DEFAULT  = 10;
   localparam int unsigned IMM_W_DEFAULT = 7;

   typedef logic [1:0] seq_state_t;

   localparam seq_state_t ST_RUN   = 2'd0;
   localparam seq_state_t ST_FLUSH = 2'd1;
   localparam seq_state_t ST_HALT  = 2'd2;

endpackage

// File: rtl/branch_address.sv
// PC-relative branch target: pc + sign_extend(immediate), wrapping modulo 2^PC_W.
module branch_address
   import mips16_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEFAULT,
   parameter int unsigned IMM_W = IMM_W_DEFAULT
) (
   input  logic [PC_W-1:0]  pc,
   input  logic [IMM_W-1:0] immediate,
   output logic [PC_W-1:0]  branch_address
);

   logic [PC_W-1:0] imm_ext;

   // Sign-extend the offset to PC width; the add then drops any carry-out.
   always_comb begin
      imm_ext        = PC_W'($signed(immediate));
      branch_address = pc + imm_ext;
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, branch/jump redirect with a
// one-cycle flush, stall hold, and halt/resume. All outputs come from flops.
module pc_sequencer
   import mips16_pkg::*;
#(
   parameter int unsigned     PC_W     = PC_W_DEFAULT,
   parameter int unsigned     IMM_W    = IMM_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [PC_W-1:0]  branch_pc,
   input  logic [IMM_W-1:0] branch_imm,
   input  logic             jump,
   input  logic [PC_W-1:0]  jump_target,
   input  logic             halt,
   input  logic             resume,
   output logic [PC_W-1:0]  pc,
   output logic             fetch_valid,
   output logic             flush,
   output logic             halted
);

   seq_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            fetch_valid_q, fetch_valid_d;
   logic            flush_q, flush_d;
   logic            halted_q, halted_d;
   // Set by reset: the first advancing edge validates RESET_PC instead of
   // stepping past it.
   logic            boot_q, boot_d;

   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] redirect_pc;
   logic            redirect;

   branch_address #(
      .PC_W  (PC_W),
      .IMM_W (IMM_W)
   ) u_branch_address (
      .pc             (branch_pc),
      .immediate      (branch_imm),
      .branch_address (br_target)
   );

   // Redirect selection: a taken branch wins over a jump in the same cycle.
   always_comb begin
      redirect    = branch_taken | jump;
      redirect_pc = branch_taken ? br_target : jump_target;
      pc_inc      = pc_q + PC_W'(1);
   end

   // Next-state logic: redirect > halt > stall > sequential increment.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_valid_d = 1'b0;
      flush_d       = 1'b0;
      halted_d      = 1'b0;
      boot_d        = boot_q;

      case (state_q)
         ST_RUN, ST_FLUSH: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               flush_d = 1'b1;
               state_d = ST_FLUSH;
               boot_d  = 1'b0;
            end else if ((state_q == ST_RUN) && halt) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
               boot_d   = 1'b0;
            end else if (stall) begin
               state_d = ST_RUN;
            end else begin
               pc_d          = boot_q ? pc_q : pc_inc;
               fetch_valid_d = 1'b1;
               state_d       = ST_RUN;
               boot_d        = 1'b0;
            end
         end
         ST_HALT: begin
            if (resume) begin
               pc_d          = pc_inc;
               fetch_valid_d = 1'b1;
               state_d       = ST_RUN;
            end else begin
               halted_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State and output registers; reset takes effect without a clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
         halted_q      <= 1'b0;
         boot_q        <= 1'b1;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
         halted_q      <= halted_d;
         boot_q        <= boot_d;
      end
   end

   assign pc          = pc_q;
   assign fetch_valid = fetch_valid_q;
   assign flush       = flush_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PC_W=10, IMM_W=7, RESET_PC=0).
// Observed tuple is {pc, flush, fetch_valid, halted}.
module tb_pc_sequencer;

   logic       clk;
   logic       rst;
   logic       stall;
   logic       branch_taken;
   logic [9:0] branch_pc;
   logic [6:0] branch_imm;
   logic       jump;
   logic [9:0] jump_target;
   logic       halt;
   logic       resume;
   logic [9:0] pc;
   logic       fetch_valid;
   logic       flush;
   logic       halted;

   int unsigned n_cmp;
   int unsigned n_err;

   logic [12:0] act_v;
   logic [12:0] exp_v;

   logic [9:0] wr_bpc  [3] = '{10'd80, 10'd1023, 10'd2};
   logic [6:0] wr_bimm [3] = '{7'd30, 7'd10, 7'h76};
   logic [9:0] wr_exp  [3] = '{10'd110, 10'd9, 10'd1016};

   pc_sequencer #(
      .PC_W     (10),
      .IMM_W    (7),
      .RESET_PC (10'd0)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_pc    (branch_pc),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_target  (jump_target),
      .halt         (halt),
      .resume       (resume),
      .pc           (pc),
      .fetch_valid  (fetch_valid),
      .flush        (flush),
      .halted       (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd0, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL reset_hold: got %h expected %h", act_v, exp_v);
      end
      rst = 1'b0;
      step();
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd0, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL reset_first_edge: got %h expected %h", act_v, exp_v);
      end
      step();
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd1, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL reset_second_edge: got %h expected %h", act_v, exp_v);
      end
   endtask

   task automatic test_branch_back();
      branch_pc    = 10'd80;
      branch_imm   = 7'h62;   // -30
      branch_taken = 1'b1;
      step();
      branch_taken = 1'b0;
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd50, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL branch_back_target: got %h expected %h", act_v, exp_v);
      end
      step();
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd51, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL branch_back_after: got %h expected %h", act_v, exp_v);
      end
   endtask

   task automatic test_branch_wrap();
      for (int i = 0; i < 3; i++) begin
         branch_pc    = wr_bpc[i];
         branch_imm   = wr_bimm[i];
         branch_taken = 1'b1;
         step();
         branch_taken = 1'b0;
         act_v = {pc, flush, fetch_valid, halted};
         exp_v = {wr_exp[i], 1'b1, 1'b0, 1'b0};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL branch_wrap_%0d: got %h expected %h", i, act_v, exp_v);
         end
         step();
         act_v = {pc, flush, fetch_valid, halted};
         exp_v = {wr_exp[i] + 10'd1, 1'b0, 1'b1, 1'b0};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL branch_wrap_next_%0d: got %h expected %h", i, act_v, exp_v);
         end
      end
   endtask

   task automatic test_free_run_stall();
      logic [9:0] seq [3] = '{10'd1023, 10'd0, 10'd1};
      jump        = 1'b1;
      jump_target = 10'd1022;
      step();
      jump = 1'b0;
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd1022, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL jump_1022: got %h expected %h", act_v, exp_v);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         act_v = {pc, flush, fetch_valid, halted};
         exp_v = {seq[i], 1'b0, 1'b1, 1'b0};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL free_run_%0d: got %h expected %h", i, act_v, exp_v);
         end
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         act_v = {pc, flush, fetch_valid, halted};
         exp_v = {10'd1, 1'b0, 1'b0, 1'b0};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL stall_hold_%0d: got %h expected %h", i, act_v, exp_v);
         end
      end
      stall = 1'b0;
      step();
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd2, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL stall_release: got %h expected %h", act_v, exp_v);
      end
   endtask

   task automatic test_priority();
      branch_pc    = 10'd80;
      branch_imm   = 7'h62;   // -30
      jump_target  = 10'd700;
      branch_taken = 1'b1;
      jump         = 1'b1;
      stall        = 1'b1;
      step();
      branch_taken = 1'b0;
      jump         = 1'b0;
      stall        = 1'b0;
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd50, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL priority_branch_wins: got %h expected %h", act_v, exp_v);
      end
      step();
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd51, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL priority_after: got %h expected %h", act_v, exp_v);
      end
   endtask

   task automatic test_halt();
      jump        = 1'b1;
      jump_target = 10'd199;
      step();
      jump = 1'b0;
      step();
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd200, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL halt_setup: got %h expected %h", act_v, exp_v);
      end
      halt = 1'b1;
      step();
      halt = 1'b0;
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd200, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL halt_enter: got %h expected %h", act_v, exp_v);
      end
      branch_pc  = 10'd80;
      branch_imm = 7'h62;
      for (int i = 0; i < 5; i++) begin
         branch_taken = ~branch_taken;
         jump         = (i == 2);
         stall        = (i == 3);
         step();
         act_v = {pc, flush, fetch_valid, halted};
         exp_v = {10'd200, 1'b0, 1'b0, 1'b1};
         n_cmp++;
         if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL halt_ignore_%0d: got %h expected %h", i, act_v, exp_v);
         end
      end
      branch_taken = 1'b0;
      jump         = 1'b0;
      stall        = 1'b0;
      resume       = 1'b1;
      step();
      resume = 1'b0;
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd201, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL halt_resume: got %h expected %h", act_v, exp_v);
      end
   endtask

   task automatic test_reset_mid_op();
      // Reset while flushing.
      branch_pc    = 10'd80;
      branch_imm   = 7'd30;
      branch_taken = 1'b1;
      step();
      branch_taken = 1'b0;
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd110, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL mid_flush_setup: got %h expected %h", act_v, exp_v);
      end
      #2;
      rst = 1'b1;
      #1;
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd0, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL mid_flush_async_reset: got %h expected %h", act_v, exp_v);
      end
      step();
      rst = 1'b0;
      step();
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd0, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL mid_flush_release: got %h expected %h", act_v, exp_v);
      end
      // Reset while halted.
      halt = 1'b1;
      step();
      halt = 1'b0;
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd0, 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL mid_halt_setup: got %h expected %h", act_v, exp_v);
      end
      #3;
      rst = 1'b1;
      #1;
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd0, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL mid_halt_async_reset: got %h expected %h", act_v, exp_v);
      end
      step();
      rst = 1'b0;
      step();
      step();
      act_v = {pc, flush, fetch_valid, halted};
      exp_v = {10'd1, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (act_v !== exp_v) begin
         n_err++;
         $display("FAIL mid_halt_release: got %h expected %h", act_v, exp_v);
      end
   endtask

   initial begin
      n_cmp        = 0;
      n_err        = 0;
      rst          = 1'b1;
      stall        = 1'b0;
      branch_taken = 1'b0;
      branch_pc    = '0;
      branch_imm   = '0;
      jump         = 1'b0;
      jump_target  = '0;
      halt         = 1'b0;
      resume       = 1'b0;

      test_reset();
      test_branch_back();
      test_branch_wrap();
      test_free_run_stall();
      test_priority();
      test_halt();
      test_reset_mid_op();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
